// File: rtl/ysyx_24080014_mem_arbiter.sv
// Two-requester memory arbiter. The IFU and the LSU share one data-memory port.
// One transaction is outstanding at a time. The LSU has fixed priority, and the
// IFU is still served after STARVE_LIMIT back-to-back LSU grants while it waits.
module ysyx_24080014_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rsp_valid,
    output logic [31:0] ifu_rsp_data,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_rsp_valid,
    output logic [31:0] lsu_rsp_data,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,

    output logic        busy
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    logic [1:0]        state_q,      state_d;
    logic              owner_q,      owner_d;
    logic [DATA_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic              wen_q,        wen_d;
    logic [3:0]        wmask_q,      wmask_d;
    logic [DATA_W-1:0] rdata_q,      rdata_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic lsu_grant;
    logic ifu_grant;

    // Grant in IDLE: LSU first, unless the IFU has waited through STARVE_LIMIT LSU grants.
    always_comb begin
        lsu_grant = 1'b0;
        ifu_grant = 1'b0;
        if (state_q == S_IDLE) begin
            lsu_grant = lsu_req_valid &&
                        !(ifu_req_valid && (starve_cnt_q == CNT_W'(STARVE_LIMIT)));
            ifu_grant = ifu_req_valid && !lsu_grant;
        end
    end

    // Next state, request capture, response capture and starvation counting.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wen_d        = wen_q;
        wmask_d      = wmask_q;
        rdata_d      = rdata_q;
        starve_cnt_d = starve_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (lsu_grant) begin
                    owner_d      = OWNER_LSU;
                    addr_d       = lsu_addr;
                    wen_d        = lsu_wen;
                    wdata_d      = lsu_wdata;
                    wmask_d      = lsu_wmask;
                    starve_cnt_d = ifu_req_valid ? (starve_cnt_q + CNT_W'(1)) : '0;
                    state_d      = S_ISSUE;
                end else if (ifu_grant) begin
                    owner_d      = OWNER_IFU;
                    addr_d       = ifu_addr;
                    wen_d        = 1'b0;
                    wdata_d      = '0;
                    wmask_d      = '0;
                    starve_cnt_d = '0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    rdata_d = mem_rsp_data;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= OWNER_IFU;
            addr_q       <= '0;
            wdata_q      <= '0;
            wen_q        <= 1'b0;
            wmask_q      <= '0;
            rdata_q      <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wen_q        <= wen_d;
            wmask_q      <= wmask_d;
            rdata_q      <= rdata_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Outputs are decoded from registered state. The ready signals follow the IDLE grant.
    assign ifu_req_ready = ifu_grant;
    assign lsu_req_ready = lsu_grant;
    assign mem_req_valid = (state_q == S_ISSUE);
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wen       = wen_q;
    assign mem_wmask     = wmask_q;
    assign ifu_rsp_valid = (state_q == S_RESP) && (owner_q == OWNER_IFU);
    assign lsu_rsp_valid = (state_q == S_RESP) && (owner_q == OWNER_LSU);
    assign ifu_rsp_data  = rdata_q;
    assign lsu_rsp_data  = rdata_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_ysyx_24080014_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter.
// Inputs are driven 1ns after the rising edge, and outputs are sampled 1ns after that.
module tb_ysyx_24080014_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        busy;

    int vectors;
    int miscompares;

    ysyx_24080014_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wen       (mem_wen),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory side for a request now in ISSUE: accept at once, respond on the next cycle.
    // On return the arbiter is in RESP.
    task automatic mem_serve(input logic [31:0] d);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = d;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (mem_req_valid !== 1'b0 || busy !== 1'b0 || ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: mem_req_valid=%b busy=%b ifu_rsp=%b lsu_rsp=%b, want all 0",
                     mem_req_valid, busy, ifu_rsp_valid, lsu_rsp_valid);
        end
        vectors++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wen !== 1'b0 || mem_wmask !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_mem: addr=%h wdata=%h wen=%b wmask=%h, want all 0",
                     mem_addr, mem_wdata, mem_wen, mem_wmask);
        end
        ifu_req_valid = 1'b1;
        #1;
        vectors++;
        if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_grant: ifu_ready=%b lsu_ready=%b, want 1 0", ifu_req_ready, lsu_req_ready);
        end
        ifu_req_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ifu_fetch();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        #1;
        vectors++;
        if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_grant: ifu_ready=%b lsu_ready=%b, want 1 0", ifu_req_ready, lsu_req_ready);
        end
        step();
        ifu_req_valid = 1'b0;
        ifu_addr      = 32'h0;
        vectors++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_issue: valid=%b addr=%h wen=%b busy=%b, want 1 80000000 0 1",
                     mem_req_valid, mem_addr, mem_wen, busy);
        end
        mem_serve(32'h0000_0413);
        vectors++;
        if (ifu_rsp_valid !== 1'b1 || ifu_rsp_data !== 32'h0000_0413 || lsu_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_rsp: ifu_rsp=%b data=%h lsu_rsp=%b, want 1 00000413 0",
                     ifu_rsp_valid, ifu_rsp_data, lsu_rsp_valid);
        end
        step();
        vectors++;
        if (ifu_rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_pulse: ifu_rsp=%b busy=%b, want 0 0", ifu_rsp_valid, busy);
        end
    endtask

    task automatic test_lsu_store();
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b1;
        lsu_addr      = 32'h8000_1004;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'b1100;
        #1;
        vectors++;
        if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL store_grant: lsu_ready=%b ifu_ready=%b, want 1 0", lsu_req_ready, ifu_req_ready);
        end
        step();
        // The request fields may change after the accept; the registered copy must not.
        lsu_req_valid = 1'b0;
        lsu_addr      = 32'h0BAD_0BAD;
        lsu_wen       = 1'b0;
        lsu_wmask     = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_1004 || mem_wdata !== 32'hDEAD_BEEF ||
                mem_wen !== 1'b1 || mem_wmask !== 4'b1100) begin
                miscompares++;
                $display("FAIL store_hold[%0d]: valid=%b addr=%h wdata=%h wen=%b wmask=%b, want 1 80001004 deadbeef 1 1100",
                         i, mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_wmask);
            end
            step();
        end
        mem_serve(32'h0);
        vectors++;
        if (lsu_rsp_valid !== 1'b1 || ifu_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL store_rsp: lsu_rsp=%b ifu_rsp=%b, want 1 0", lsu_rsp_valid, ifu_rsp_valid);
        end
        step();
        vectors++;
        if (lsu_rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL store_pulse: lsu_rsp=%b busy=%b, want 0 0", lsu_rsp_valid, busy);
        end
    endtask

    task automatic test_contention();
        // Grant order with STARVE_LIMIT=4, index 0 first: LSU x4, IFU, LSU x4, IFU.
        logic [9:0] exp_lsu;
        exp_lsu = 10'b01111_01111;
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0100;
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b0;
        lsu_addr      = 32'h8000_2000;
        #1;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (lsu_req_ready !== exp_lsu[i] || ifu_req_ready !== !exp_lsu[i]) begin
                miscompares++;
                $display("FAIL contention_grant[%0d]: lsu_ready=%b ifu_ready=%b, want %b %b",
                         i, lsu_req_ready, ifu_req_ready, exp_lsu[i], !exp_lsu[i]);
            end
            step();
            vectors++;
            if (dut.starve_cnt_q > 4'd4 || lsu_req_ready !== 1'b0 || ifu_req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL contention_issue[%0d]: starve_cnt=%0d lsu_ready=%b ifu_ready=%b, want <=4 0 0",
                         i, dut.starve_cnt_q, lsu_req_ready, ifu_req_ready);
            end
            mem_serve(32'hC000_0000 + 32'(i));
            vectors++;
            if (lsu_rsp_valid !== exp_lsu[i] || ifu_rsp_valid !== !exp_lsu[i] ||
                lsu_rsp_data !== (32'hC000_0000 + 32'(i))) begin
                miscompares++;
                $display("FAIL contention_rsp[%0d]: lsu_rsp=%b ifu_rsp=%b data=%h, want %b %b %h",
                         i, lsu_rsp_valid, ifu_rsp_valid, lsu_rsp_data, exp_lsu[i], !exp_lsu[i],
                         32'hC000_0000 + 32'(i));
            end
            step();
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        step();
    endtask

    task automatic test_ifu_idle();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            lsu_addr = 32'h8000_3000 + 32'(i * 4);
            #1;
            vectors++;
            if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_grant[%0d]: lsu_ready=%b ifu_ready=%b, want 1 0", i, lsu_req_ready, ifu_req_ready);
            end
            step();
            vectors++;
            if (dut.starve_cnt_q !== 4'd0 || mem_addr !== 32'h8000_3000 + 32'(i * 4)) begin
                miscompares++;
                $display("FAIL idle_issue[%0d]: starve_cnt=%0d addr=%h, want 0 %h",
                         i, dut.starve_cnt_q, mem_addr, 32'h8000_3000 + 32'(i * 4));
            end
            mem_serve(32'h5000_0000 + 32'(i));
            vectors++;
            if (lsu_rsp_valid !== 1'b1 || lsu_rsp_data !== 32'h5000_0000 + 32'(i)) begin
                miscompares++;
                $display("FAIL idle_rsp[%0d]: lsu_rsp=%b data=%h, want 1 %h",
                         i, lsu_rsp_valid, lsu_rsp_data, 32'h5000_0000 + 32'(i));
            end
            step();
        end
        lsu_req_valid = 1'b0;
        step();
    endtask

    task automatic test_spurious();
        // Response in IDLE must be ignored.
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0BAD_0001;
        step();
        mem_rsp_valid = 1'b0;
        vectors++;
        if (busy !== 1'b0 || ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_idle: busy=%b ifu_rsp=%b lsu_rsp=%b, want 0 0 0", busy, ifu_rsp_valid, lsu_rsp_valid);
        end
        // The leftover LSU store fields must not leak into an IFU request.
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'hF;
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0010;
        step();
        ifu_req_valid = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0BAD_0002;
        step();
        mem_rsp_valid = 1'b0;
        vectors++;
        if (mem_req_valid !== 1'b1 || mem_wen !== 1'b0 || mem_wdata !== 32'h0 || mem_wmask !== 4'h0 ||
            ifu_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_issue: valid=%b wen=%b wdata=%h wmask=%h ifu_rsp=%b, want 1 0 0 0 0",
                     mem_req_valid, mem_wen, mem_wdata, mem_wmask, ifu_rsp_valid);
        end
        // A response in the same cycle as the accept is not captured.
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0BAD_0003;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        step();
        vectors++;
        if (mem_req_valid !== 1'b0 || busy !== 1'b1 || ifu_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_wait: valid=%b busy=%b ifu_rsp=%b, want 0 1 0", mem_req_valid, busy, ifu_rsp_valid);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1234_5678;
        step();
        mem_rsp_valid = 1'b0;
        vectors++;
        if (ifu_rsp_valid !== 1'b1 || ifu_rsp_data !== 32'h1234_5678 || lsu_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_rsp: ifu_rsp=%b data=%h lsu_rsp=%b, want 1 12345678 0",
                     ifu_rsp_valid, ifu_rsp_data, lsu_rsp_valid);
        end
        step();
        vectors++;
        if (busy !== 1'b0 || ifu_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_done: busy=%b ifu_rsp=%b, want 0 0", busy, ifu_rsp_valid);
        end
    endtask

    task automatic test_reset_mid_wait();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0020;
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0 || mem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL rstmid_assert: busy=%b valid=%b addr=%h, want 0 0 0", busy, mem_req_valid, mem_addr);
        end
        step();
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0BAD_0004;
        step();
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (busy !== 1'b0 || ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_quiet[%0d]: busy=%b ifu_rsp=%b lsu_rsp=%b, want 0 0 0",
                         i, busy, ifu_rsp_valid, lsu_rsp_valid);
            end
            step();
        end
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0030;
        #1;
        vectors++;
        if (ifu_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_grant: ifu_ready=%b, want 1", ifu_req_ready);
        end
        step();
        ifu_req_valid = 1'b0;
        mem_serve(32'hCAFE_F00D);
        vectors++;
        if (ifu_rsp_valid !== 1'b1 || ifu_rsp_data !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL rstmid_rsp: ifu_rsp=%b data=%h, want 1 cafef00d", ifu_rsp_valid, ifu_rsp_data);
        end
        step();
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        ifu_req_valid = 1'b0;
        ifu_addr      = 32'h0;
        lsu_req_valid = 1'b0;
        lsu_addr      = 32'h0;
        lsu_wen       = 1'b0;
        lsu_wdata     = 32'h0;
        lsu_wmask     = 4'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        step();

        test_reset();
        test_ifu_fetch();
        test_lsu_store();
        test_contention();
        test_ifu_idle();
        test_spurious();
        test_reset_mid_wait();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
